// File: rtl/bit_route_pkg.sv
// Shared types for the bit-level routing controller: FSM states and routing table entry.
package bit_route_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        ACK    = 2'd2
    } route_state_e;

    // Entry src field is sized for the widest supported source bus; instances use the low SEL_W bits.
    localparam int ROUTE_SEL_MAX_W = 8;

    typedef struct packed {
        logic                       en;
        logic [ROUTE_SEL_MAX_W-1:0] src;
    } route_entry_t;

    localparam route_entry_t ROUTE_ENTRY_RESET = '{en: 1'b0, src: '0};

endpackage

// File: rtl/bit_route_mux.sv
// One routed sink bit: SRC_W:1 select from the source bus, gated by the entry enable.
module bit_route_mux
    import bit_route_pkg::*;
#(
    parameter int SRC_W = 2,
    parameter int SEL_W = $clog2(SRC_W)
) (
    input  logic [SRC_W-1:0]           source_bus,
    input  logic [ROUTE_SEL_MAX_W-1:0] sel,
    input  logic                       en,
    output logic                       y
);

    // Out-of-range selects cannot be stored, but are still forced to 0 defensively.
    always_comb begin
        y = 1'b0;
        if (en && (int'(sel) < SRC_W)) begin
            y = source_bus[sel[SEL_W-1:0]];
        end
    end

endmodule

// File: rtl/bit_route_ctrl.sv
// Runtime bit routing controller: shadow table loaded over cfg port, atomically committed to active table.
// Optional commit counter output enabled by defining BIT_ROUTE_CTRL_COMMIT_CNT_EN.
module bit_route_ctrl
    import bit_route_pkg::*;
#(
    parameter int SRC_W = 2,
    parameter int SNK_W = 2,
    parameter int IDX_W = $clog2(SNK_W + 1),
    parameter int SEL_W = $clog2(SRC_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [SEL_W-1:0] cfg_src,
    input  logic             cfg_en,
    input  logic             commit_req,
    output logic             commit_ack,
    input  logic [SRC_W-1:0] source_bus,
    output logic [SNK_W-1:0] sink_bus,
    output logic             scalar_sink,
    output logic             busy,
`ifdef BIT_ROUTE_CTRL_COMMIT_CNT_EN
    output logic [7:0]       commit_cnt,
`endif
    output logic             cfg_err
);

    route_state_e state_reg;
    logic         commit_ack_reg;
    logic         busy_reg;
    logic         cfg_err_reg;
    route_entry_t shadow_reg [SNK_W+1];
    route_entry_t active_reg [SNK_W+1];
    logic [SNK_W:0] route_next;
    logic [SNK_W:0] out_reg;
    logic         wr_fire;
    logic         wr_ok;

    // A pending commit request takes priority over configuration writes.
    assign cfg_ready = (state_reg == IDLE) && !commit_req;
    assign wr_fire   = cfg_valid && cfg_ready;
    assign wr_ok     = (int'(cfg_idx) <= SNK_W) && (int'(cfg_src) < SRC_W);

    genvar gi;
    generate
        for (gi = 0; gi <= SNK_W; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg[gi] <= ROUTE_ENTRY_RESET;
                end else if (wr_fire && wr_ok && (cfg_idx == IDX_W'(gi))) begin
                    shadow_reg[gi] <= '{en: cfg_en, src: ROUTE_SEL_MAX_W'(cfg_src)};
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    active_reg[gi] <= ROUTE_ENTRY_RESET;
                end else if (state_reg == COMMIT) begin
                    active_reg[gi] <= shadow_reg[gi];
                end
            end

            bit_route_mux #(
                .SRC_W (SRC_W),
                .SEL_W (SEL_W)
            ) u_mux (
                .source_bus (source_bus),
                .sel        (active_reg[gi].src),
                .en         (active_reg[gi].en),
                .y          (route_next[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg <= '0;
        end else begin
            out_reg <= route_next;
        end
    end

    assign sink_bus    = out_reg[SNK_W-1:0];
    assign scalar_sink = out_reg[SNK_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            commit_ack_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (commit_req) begin
                        state_reg <= COMMIT;
                        busy_reg  <= 1'b1;
                    end
                end
                COMMIT: begin
                    state_reg      <= ACK;
                    commit_ack_reg <= 1'b1;
                end
                ACK: begin
                    state_reg      <= IDLE;
                    commit_ack_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                end
                default: begin
                    state_reg      <= IDLE;
                    commit_ack_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign commit_ack = commit_ack_reg;
    assign busy       = busy_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_reg <= 1'b0;
        end else if (wr_fire && !wr_ok) begin
            cfg_err_reg <= 1'b1;
        end
    end

    assign cfg_err = cfg_err_reg;

`ifdef BIT_ROUTE_CTRL_COMMIT_CNT_EN
    logic [7:0] commit_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_cnt_reg <= 8'd0;
        end else if (state_reg == COMMIT) begin
            commit_cnt_reg <= commit_cnt_reg + 8'd1;
        end
    end

    assign commit_cnt = commit_cnt_reg;
`endif

endmodule

// File: tb/tb_bit_route_ctrl.sv
// Randomized self-checking bench for bit_route_ctrl against a table-level reference model.
module tb_bit_route_ctrl;

    localparam int SRC_W = 2;
    localparam int SNK_W = 2;
    localparam int IDX_W = 2;
    localparam int SEL_W = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [IDX_W-1:0] cfg_idx;
    logic [SEL_W-1:0] cfg_src;
    logic             cfg_en;
    logic             commit_req;
    logic             commit_ack;
    logic [SRC_W-1:0] source_bus;
    logic [SNK_W-1:0] sink_bus;
    logic             scalar_sink;
    logic             busy;
    logic             cfg_err;
`ifdef BIT_ROUTE_CTRL_COMMIT_CNT_EN
    logic [7:0]       commit_cnt;
`endif

    bit_route_ctrl #(
        .SRC_W (SRC_W),
        .SNK_W (SNK_W),
        .IDX_W (IDX_W),
        .SEL_W (SEL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_idx     (cfg_idx),
        .cfg_src     (cfg_src),
        .cfg_en      (cfg_en),
        .commit_req  (commit_req),
        .commit_ack  (commit_ack),
        .source_bus  (source_bus),
        .sink_bus    (sink_bus),
        .scalar_sink (scalar_sink),
        .busy        (busy),
`ifdef BIT_ROUTE_CTRL_COMMIT_CNT_EN
        .commit_cnt  (commit_cnt),
`endif
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    // Reference model: shadow and active tables as plain arrays, indexed by sink number.
    int         sh_en  [SNK_W+1];
    int         sh_src [SNK_W+1];
    int         ac_en  [SNK_W+1];
    int         ac_src [SNK_W+1];
    bit         err_m;
    logic [7:0] cnt_m;
    bit         pend_wr;
    int         pw_idx, pw_src, pw_en;
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic routed(input int i, input logic [SRC_W-1:0] sb);
        if (ac_en[i] == 0) return 1'b0;
        return sb[ac_src[i]];
    endfunction

    task automatic clear_model();
        for (int i = 0; i <= SNK_W; i++) begin
            sh_en[i] = 0; sh_src[i] = 0; ac_en[i] = 0; ac_src[i] = 0;
        end
        err_m   = 1'b0;
        cnt_m   = 8'd0;
        pend_wr = 1'b0;
    endtask

    // One clock: predict outputs from this cycle's source, apply any accepted write, check.
    task automatic cycle();
        logic [SNK_W:0] exp;
        for (int i = 0; i <= SNK_W; i++) exp[i] = routed(i, source_bus);
        @(posedge clk);
        #1;
        if (pend_wr) begin
            if (pw_idx <= SNK_W && pw_src < SRC_W) begin
                sh_en[pw_idx]  = pw_en;
                sh_src[pw_idx] = pw_src;
            end else begin
                err_m = 1'b1;
            end
            pend_wr = 1'b0;
        end
        chk("sink_bus", 32'(sink_bus), 32'(exp[SNK_W-1:0]));
        chk("scalar_sink", 32'(scalar_sink), 32'(exp[SNK_W]));
        chk("cfg_err", 32'(cfg_err), 32'(err_m));
        source_bus = SRC_W'($urandom);
    endtask

    task automatic wr(input int idx, input int src, input int en);
        cfg_valid = 1'b1;
        cfg_idx   = IDX_W'(idx);
        cfg_src   = SEL_W'(src);
        cfg_en    = en[0];
        #1;
        chk("wr_ready", 32'(cfg_ready), 32'd1);
        pw_idx = idx; pw_src = src; pw_en = en;
        pend_wr = 1'b1;
        cycle();
        cfg_valid = 1'b0;
    endtask

    // with_wr: cfg_valid is already held high with a write that must stall behind the commit.
    task automatic commit(input bit with_wr);
        commit_req = 1'b1;
        #1;
        chk("req_ready", 32'(cfg_ready), 32'd0);
        cycle();
        chk("commit_busy", 32'(busy), 32'd1);
        chk("commit_noack", 32'(commit_ack), 32'd0);
        chk("commit_ready", 32'(cfg_ready), 32'd0);
        cycle();
        chk("ack_pulse", 32'(commit_ack), 32'd1);
        chk("ack_busy", 32'(busy), 32'd1);
        for (int i = 0; i <= SNK_W; i++) begin
            ac_en[i]  = sh_en[i];
            ac_src[i] = sh_src[i];
        end
        cnt_m = cnt_m + 8'd1;
        commit_req = 1'b0;
        #1;
        chk("ack_ready", 32'(cfg_ready), 32'd0);
        cycle();
        chk("idle_ack", 32'(commit_ack), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
`ifdef BIT_ROUTE_CTRL_COMMIT_CNT_EN
        chk("commit_cnt", 32'(commit_cnt), 32'(cnt_m));
`endif
        if (with_wr) begin
            chk("stall_ready", 32'(cfg_ready), 32'd1);
            pend_wr = 1'b1;
            cycle();
            cfg_valid = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_idx = '0; cfg_src = '0; cfg_en = 1'b0;
        commit_req = 1'b0; source_bus = 2'b11;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sink", 32'(sink_bus), 32'd0);
        chk("rst_scalar", 32'(scalar_sink), 32'd0);
        chk("rst_ack", 32'(commit_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
`ifdef BIT_ROUTE_CTRL_COMMIT_CNT_EN
        chk("rst_cnt", 32'(commit_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        source_bus = 2'b11;
        cycle();
        chk("tp1_sink", 32'(sink_bus), 32'd0);

        // Program bus bit1 from src1 and scalar from src0, bus bit0 left disabled.
        wr(1, 1, 1);
        wr(2, 0, 1);
        commit(1'b0);
        source_bus = 2'b10;
        cycle();
        chk("tp2_sink", 32'(sink_bus), 32'd2);
        chk("tp2_scalar", 32'(scalar_sink), 32'd0);
        source_bus = 2'b01;
        cycle();
        chk("tp2b_sink", 32'(sink_bus), 32'd0);
        chk("tp2b_scalar", 32'(scalar_sink), 32'd1);

        // Shadow-only write must not reach the outputs until committed.
        wr(0, 1, 1);
        repeat (12) cycle();
        commit(1'b0);
        repeat (4) cycle();

        // Out-of-range index: error set, table untouched, flag survives a commit.
        wr(3, 1, 0);
        chk("err_set", 32'(cfg_err), 32'd1);
        commit(1'b0);
        repeat (3) cycle();

        // Write and commit raised together: commit wins, write lands after ACK.
        cfg_valid = 1'b1; cfg_idx = 2'd0; cfg_src = 1'b0; cfg_en = 1'b1;
        pw_idx = 0; pw_src = 0; pw_en = 1;
        commit(1'b1);
        repeat (3) cycle();
        commit(1'b0);
        repeat (3) cycle();

        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) wr($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
            else if (r == 5) commit(1'b0);
            else cycle();
        end

        // Reset in the middle of COMMIT.
        commit_req = 1'b1;
        #1;
        cycle();
        rst_n = 1'b0;
        commit_req = 1'b0;
        #1;
        clear_model();
        chk("midrst_ack", 32'(commit_ack), 32'd0);
        chk("midrst_sink", 32'(sink_bus), 32'd0);
        chk("midrst_scalar", 32'(scalar_sink), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_err", 32'(cfg_err), 32'd0);
`ifdef BIT_ROUTE_CTRL_COMMIT_CNT_EN
        chk("midrst_cnt", 32'(commit_cnt), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_noack", 32'(commit_ack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle();
        commit(1'b0);
        source_bus = 2'b11;
        cycle();
        chk("post_rst_sink", 32'(sink_bus), 32'd0);

`ifdef BIT_ROUTE_CTRL_COMMIT_CNT_EN
        wr(0, 1, 1);
        for (int n = 0; n < 255; n++) commit(1'b0);
        chk("cnt_wrap", 32'(commit_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
